// File: rtl/sr_puf_controller_if.sv
// Host-side handshake of the SR-latch PUF sequencer: challenge request in,
// majority-voted response and stability count out.
interface sr_puf_controller_if #(
    parameter int ADDR_W    = 6,
    parameter int RESP_BITS = 8
) ();
    logic                 start;
    logic [ADDR_W-1:0]    challenge;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [3:0]           unstable_cnt;

    modport master (
        output start, challenge,
        input  busy, done, response, unstable_cnt
    );

    modport slave (
        input  start, challenge,
        output busy, done, response, unstable_cnt
    );
endinterface

// File: rtl/sr_puf_controller.sv
// Sequencer for a cross-coupled NAND SR-latch PUF array: excites each selected
// cell, releases it to resolve by mismatch, and majority-votes repeated samples.
module sr_puf_controller #(
    parameter int NUM_CELLS     = 64,
    parameter int ADDR_W        = 6,
    parameter int RESP_BITS     = 8,
    parameter int VOTES         = 5,
    parameter int EXCITE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_puf_controller_if.slave    host,
    output logic [ADDR_W-1:0]     cell_sel,
    output logic                  cell_s,
    output logic                  cell_r,
    input  logic                  cell_q
);
    localparam int TMR_MAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(RESP_BITS + 1);

    localparam logic [TMR_W-1:0]  EXCITE_LAST = TMR_W'(EXCITE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        VOTES_N     = 4'(VOTES);
    localparam logic [3:0]        VOTES_LAST  = 4'(VOTES - 1);
    localparam logic [3:0]        VOTES_HALF  = 4'(VOTES / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXCITE, S_RELEASE, S_SAMPLE, S_DECIDE, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [3:0]           vote_q, vote_d;
    logic [3:0]           ones_q, ones_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [RESP_BITS-1:0] shift_q, shift_d;
    logic [3:0]           unst_q, unst_d;
    logic [1:0]           sync_q;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [3:0]           unst_out_q, unst_out_d;
    logic [ADDR_W-1:0]    sel_q, sel_d;
    logic                 cell_ctl_q, cell_ctl_d;

    logic q_sync;
    assign q_sync = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            bit_idx_q  <= '0;
            vote_q     <= '0;
            ones_q     <= '0;
            tmr_q      <= '0;
            shift_q    <= '0;
            unst_q     <= '0;
            sync_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= '0;
            unst_out_q <= '0;
            sel_q      <= '0;
            cell_ctl_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            bit_idx_q  <= bit_idx_d;
            vote_q     <= vote_d;
            ones_q     <= ones_d;
            tmr_q      <= tmr_d;
            shift_q    <= shift_d;
            unst_q     <= unst_d;
            sync_q     <= {sync_q[0], cell_q};
            busy_q     <= busy_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
            unst_out_q <= unst_out_d;
            sel_q      <= sel_d;
            cell_ctl_q <= cell_ctl_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        bit_idx_d = bit_idx_q;
        vote_d    = vote_q;
        ones_d    = ones_q;
        tmr_d     = tmr_q;
        shift_d   = shift_q;
        unst_d    = unst_q;
        unique case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    base_d    = host.challenge;
                    bit_idx_d = '0;
                    vote_d    = '0;
                    ones_d    = '0;
                    tmr_d     = '0;
                    shift_d   = '0;
                    unst_d    = '0;
                    state_d   = S_EXCITE;
                end
            end
            S_EXCITE: begin
                if (tmr_q == EXCITE_LAST) begin
                    tmr_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                ones_d  = ones_q + {3'b000, q_sync};
                vote_d  = vote_q + 1'b1;
                state_d = (vote_q == VOTES_LAST) ? S_DECIDE : S_EXCITE;
            end
            S_DECIDE: begin
                // Shifting in from the top leaves the first bit at response[0].
                shift_d = {(ones_q > VOTES_HALF), shift_q[RESP_BITS-1:1]};
                if (ones_q != 4'd0 && ones_q != VOTES_N && unst_q != 4'd15)
                    unst_d = unst_q + 1'b1;
                ones_d    = '0;
                vote_d    = '0;
                bit_idx_d = bit_idx_q + 1'b1;
                state_d   = (bit_idx_q == BIT_LAST) ? S_DONE : S_EXCITE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered, so they are
    // aligned with the state they describe.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        cell_ctl_d = (state_d != S_EXCITE);
        sel_d      = (base_d + ADDR_W'(bit_idx_d)) & ADDR_MASK;
        resp_d     = (state_d == S_DONE) ? shift_d : resp_q;
        unst_out_d = (state_d == S_DONE) ? unst_d : unst_out_q;
    end

    assign host.busy         = busy_q;
    assign host.done         = done_q;
    assign host.response     = resp_q;
    assign host.unstable_cnt = unst_out_q;
    assign cell_sel          = sel_q;
    assign cell_s            = cell_ctl_q;
    assign cell_r            = cell_ctl_q;
endmodule

// File: doc/sr_puf_controller.md
Name: sr_puf_controller

Overview:
Sequencer for the cross-coupled NAND SR-latch PUF cell array. For each response bit it selects one latch and excites it with S=R=0. It then releases both inputs to 1 at the same time so the latch resolves by mismatch, and samples the result through a synchronizer. Each cell is evaluated VOTES times and a majority vote gives the response bit. The block sits between the challenge/response interface and the latch array mux.

Parameters:
NUM_CELLS, 64, number of latch cells in the array; power of 2
ADDR_W, 6, cell address width; equals log2(NUM_CELLS)
RESP_BITS, 8, response bits generated per challenge
VOTES, 5, evaluations per bit; odd, 1..15
EXCITE_CYCLES, 2, cycles S=R=0 is held per evaluation; >=1
SETTLE_CYCLES, 4, cycles after release before sampling; >=2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  request evaluation; accepted only in IDLE
challenge  in  ADDR_W  base cell address; latched at accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when response is valid
response  out  RESP_BITS  majority-voted response; held until next done
unstable_cnt  out  4  count of bits whose votes were not unanimous; saturates at 15
cell_sel  out  ADDR_W  address of the cell under evaluation
cell_s  out  1  latch S input (active-low set)
cell_r  out  1  latch R input (active-low reset)
cell_q  in  1  selected latch Q; asynchronous, 2-FF synchronized internally

Behaviour:
- Reset values: state IDLE, busy=0, done=0, response=0, unstable_cnt=0, cell_sel=0, cell_s=1, cell_r=1. Synchronizer flops, counters and shift register are cleared.
- Reset mid-operation aborts immediately to the reset values; the partial response is discarded.
- All outputs are registered. cell_s and cell_r always change on the same edge and are never driven to different values.
- States: IDLE -> EXCITE -> RELEASE -> SAMPLE -> (EXCITE | DECIDE) -> (EXCITE | DONE) -> IDLE.
- IDLE: cell_s=cell_r=1 (latch holds). When start=1, latch challenge into base, clear bit_idx, vote_cnt, ones_cnt, the shift register and the internal unstable counter, then go to EXCITE.
- EXCITE: cell_s=cell_r=0 for exactly EXCITE_CYCLES cycles, then go to RELEASE.
- RELEASE: cell_s=cell_r=1 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle. ones_cnt += q_sync and vote_cnt += 1. If vote_cnt reaches VOTES go to DECIDE, else go to EXCITE.
- DECIDE: one cycle. bit = (ones_cnt > VOTES/2). Shift bit into position bit_idx (first bit lands in response[0]).
  - If ones_cnt is neither 0 nor VOTES, increment the unstable counter (saturating at 15).
  - Clear ones_cnt and vote_cnt, then bit_idx += 1.
  - If bit_idx reaches RESP_BITS go to DONE, else go to EXCITE.
- DONE: one cycle with done=1. response and unstable_cnt load from the internal registers, then go to IDLE. busy=1 during DONE.
- cell_sel = (base + bit_idx) mod NUM_CELLS; wrap-around is natural ADDR_W-bit truncation. cell_sel is stable for the whole of each bit's evaluation and updates in DECIDE.
- Timing: per-bit length is VOTES*(EXCITE_CYCLES+SETTLE_CYCLES+1)+1 cycles; 36 with defaults.
  - With defaults, done is asserted 8*36+1 = 289 cycles after the cycle in which start is accepted.
- start while busy (including the DONE cycle) is ignored, with no queuing. challenge changes after accept have no effect.
- response and unstable_cnt change only in DONE or on reset.

Test Plan:
- Stable-1 model for all cells, start with challenge=0 -> done once 289 cycles after accept; response=8'hFF; unstable_cnt=0; cell_sel runs 0..7.
- Model where Q equals address bit 0, challenge=0x3E -> cell_sel runs 62,63,0,1,...,5; response=8'b10101010 (bit0=cell 62); wrap-around verified.
- Noisy cell at address 3 returning 1,0,1,1,0, challenge=0 -> response[3]=1; unstable_cnt=1.
- Waveform check -> each evaluation shows S=R=0 for exactly 2 cycles then S=R=1 for 4 cycles; S never differs from R; sampling happens after the synchronizer delay.
- start pulsed at cycle 10 and in the DONE cycle of a run -> no restart, exactly one done per accepted start, previous response held.
- rst asserted asynchronously mid-RELEASE of bit 4 -> outputs immediately at reset values; a following start completes normally with the correct response.
